// File: rtl/risc_v_lsu.sv
// Load/store unit driving a word-wide single-port memory; sub-word stores use read-modify-write.
// Latency: load 2, word store 2, sub-word store 3, error 1 edges; response held until resp_ready, requests blocked meanwhile.
module risc_v_lsu #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 5,
   parameter int BYTE_ADDR_WIDTH = ADDR_WIDTH + 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [2:0]                 req_funct3,
   input  logic [BYTE_ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]      req_wdata,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [DATA_WIDTH-1:0]      resp_rdata,
   output logic                       resp_err,
   output logic                       mem_write,
   output logic [ADDR_WIDTH-1:0]      mem_addr,
   output logic [DATA_WIDTH-1:0]      mem_wdata,
   input  logic [DATA_WIDTH-1:0]      mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                     state, state_nxt;
   logic                       accept;
   logic                       req_err;
   logic                       l_write;
   logic                       l_err;
   logic [2:0]                 l_funct3;
   logic [BYTE_ADDR_WIDTH-1:0] l_addr;
   logic [DATA_WIDTH-1:0]      l_wdata;
   logic [DATA_WIDTH-1:0]      l_rword;
   logic [7:0]                 lane_b;
   logic [15:0]                lane_h;
   logic [DATA_WIDTH-1:0]      load_data;
   logic [DATA_WIDTH-1:0]      merged;

   assign accept = req_valid && req_ready;

   always_comb begin
      req_err = 1'b0;
      case (req_funct3)
         3'b000:         req_err = 1'b0;
         3'b001:         req_err = req_addr[0];
         3'b010:         req_err = (req_addr[1:0] != 2'b00);
         3'b100:         req_err = req_write;
         3'b101:         req_err = req_write || req_addr[0];
         default:        req_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)
                  state_nxt = RESP;
               else if (req_write && req_funct3 == 3'b010)
                  state_nxt = WRITE;
               else
                  state_nxt = READ;
            end
         end
         READ:    state_nxt = l_write ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_write  <= 1'b0;
         l_err    <= 1'b0;
         l_funct3 <= '0;
         l_addr   <= '0;
         l_wdata  <= '0;
         l_rword  <= '0;
      end else begin
         if (accept) begin
            l_write  <= req_write;
            l_err    <= req_err;
            l_funct3 <= req_funct3;
            l_addr   <= req_addr;
            l_wdata  <= req_wdata;
         end
         if (state == READ)
            l_rword <= mem_rdata;
      end
   end

   // Lane selection and extension operate on the word captured in READ.
   always_comb begin
      lane_b = l_rword[7:0];
      case (l_addr[1:0])
         2'd0: lane_b = l_rword[7:0];
         2'd1: lane_b = l_rword[15:8];
         2'd2: lane_b = l_rword[23:16];
         2'd3: lane_b = l_rword[31:24];
         default: lane_b = l_rword[7:0];
      endcase
      lane_h = l_addr[1] ? l_rword[31:16] : l_rword[15:0];
      load_data = '0;
      case (l_funct3)
         3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
         3'b010:  load_data = l_rword;
         3'b100:  load_data = {24'd0, lane_b};
         3'b101:  load_data = {16'd0, lane_h};
         default: load_data = '0;
      endcase
   end

   always_comb begin
      merged = l_rword;
      case (l_funct3[1:0])
         2'b00: begin
            case (l_addr[1:0])
               2'd0: merged[7:0]   = l_wdata[7:0];
               2'd1: merged[15:8]  = l_wdata[7:0];
               2'd2: merged[23:16] = l_wdata[7:0];
               2'd3: merged[31:24] = l_wdata[7:0];
               default: merged[7:0] = l_wdata[7:0];
            endcase
         end
         2'b01: begin
            if (l_addr[1])
               merged[31:16] = l_wdata[15:0];
            else
               merged[15:0]  = l_wdata[15:0];
         end
         default: merged = l_wdata;
      endcase
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_err   = (state == RESP) && l_err;
   assign resp_rdata = (state == RESP && !l_err && !l_write) ? load_data : '0;
   assign mem_write  = (state == WRITE);
   assign mem_addr   = (state == READ || state == WRITE) ? l_addr[BYTE_ADDR_WIDTH-1:2] : '0;
   assign mem_wdata  = (state == WRITE) ? merged : '0;

endmodule

// File: tb/tb_risc_v_lsu.sv
// Randomised and directed bench for risc_v_lsu against a transaction-level memory model.
module tb_risc_v_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [6:0]  req_addr = 7'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_write;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   risc_v_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYTE_ADDR_WIDTH(7)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   logic [31:0] phys_mem [0:31];
   logic [31:0] ref_mem  [0:31];

   assign mem_rdata = phys_mem[mem_addr];
   always @(posedge clk) if (mem_write) phys_mem[mem_addr] <= mem_wdata;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Reference: byte-level view of one access.
   function automatic void model(input logic w, input logic [2:0] f3, input logic [6:0] a,
                                 input logic [31:0] wd, input logic [31:0] word,
                                 output logic err, output int lat,
                                 output logic [31:0] rdata, output logic [31:0] nword);
      int size, off;
      logic [31:0] v;
      size  = 1 << f3[1:0];
      off   = int'(a[1:0]);
      err   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (w && f3[2]) ||
              ((off % size) != 0);
      rdata = 32'd0;
      nword = word;
      lat   = 1;
      if (!err && !w) begin
         lat = 2;
         v = 32'd0;
         for (int i = 0; i < size; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
         if (!f3[2] && size < 4 && v[8*size-1])
            for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
         rdata = v;
      end else if (!err) begin
         lat = (size == 4) ? 2 : 3;
         for (int i = 0; i < size; i++) nword[8*(off+i) +: 8] = wd[8*i +: 8];
      end
   endfunction

   logic        active = 1'b0;
   int          tx_cyc = 0;
   logic        e_w, e_err;
   int          e_lat;
   logic [31:0] e_rdata, e_nword;
   logic [4:0]  e_waddr;
   int          acc_cnt = 0, hs_cnt = 0, cyc = 0, acc_at = 0, hs_at = 0;
   logic        m_err;
   int          m_lat;
   logic [31:0] m_rdata, m_nword;

   // Tracks the transaction the model expects to be in flight.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         tx_cyc <= 0;
      end else begin
         cyc <= cyc + 1;
         if (!active) begin
            if (req_valid) begin
               model(req_write, req_funct3, req_addr, req_wdata, ref_mem[req_addr[6:2]],
                     m_err, m_lat, m_rdata, m_nword);
               active  <= 1'b1;
               tx_cyc  <= 1;
               e_w     <= req_write;
               e_err   <= m_err;
               e_lat   <= m_lat;
               e_rdata <= m_rdata;
               e_nword <= m_nword;
               e_waddr <= req_addr[6:2];
               acc_cnt <= acc_cnt + 1;
               acc_at  <= cyc;
            end
         end else begin
            if (!e_err && e_w && tx_cyc == e_lat - 1) ref_mem[e_waddr] <= e_nword;
            if (tx_cyc >= e_lat && resp_ready) begin
               active <= 1'b0;
               hs_cnt <= hs_cnt + 1;
               hs_at  <= cyc;
            end else begin
               tx_cyc <= tx_cyc + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst req_ready", req_ready, 1);
         chk("rst resp_valid", resp_valid, 0);
         chk("rst resp_err", resp_err, 0);
         chk("rst resp_rdata", resp_rdata, 0);
         chk("rst mem_write", mem_write, 0);
         chk("rst mem_addr", mem_addr, 0);
         chk("rst mem_wdata", mem_wdata, 0);
      end else if (!active) begin
         chk("idle req_ready", req_ready, 1);
         chk("idle resp_valid", resp_valid, 0);
         chk("idle mem_write", mem_write, 0);
         chk("idle mem_addr", mem_addr, 0);
      end else begin
         chk("busy req_ready", req_ready, 0);
         chk("resp_valid", resp_valid, tx_cyc >= e_lat);
         chk("mem_write", mem_write, !e_err && e_w && tx_cyc == e_lat - 1);
         chk("mem_addr", mem_addr, (!e_err && tx_cyc < e_lat) ? e_waddr : 5'd0);
         if (!e_err && e_w && tx_cyc == e_lat - 1) chk("mem_wdata", mem_wdata, e_nword);
         if (tx_cyc >= e_lat) begin
            chk("resp_err", resp_err, e_err);
            chk("resp_rdata", resp_rdata, e_rdata);
         end
      end
   end

   task automatic drive(input logic w, input logic [2:0] f3, input logic [6:0] a, input logic [31:0] wd);
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
   endtask

   task automatic wait_accept();
      int n, k;
      n = acc_cnt;
      k = 0;
      while (acc_cnt == n && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (acc_cnt == n) timeout("accept");
   endtask

   task automatic wait_resp(input int bp, output logic [31:0] got);
      int n, k, vis;
      n = hs_cnt;
      k = 0;
      vis = 0;
      got = 32'hXXXXXXXX;
      while (hs_cnt == n && k < 40) begin
         if (active && tx_cyc >= e_lat) begin
            vis++;
            if (vis > bp) begin
               resp_ready = 1'b1;
               got = resp_rdata;
            end
         end
         @(negedge clk);
         k++;
      end
      resp_ready = 1'b0;
      if (hs_cnt == n) timeout("response");
   endtask

   task automatic issue(input logic w, input logic [2:0] f3, input logic [6:0] a,
                        input logic [31:0] wd, input int bp, output logic [31:0] got);
      @(negedge clk);
      drive(w, f3, a, wd);
      wait_accept();
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = 7'($urandom);
      req_wdata  = $urandom;
      wait_resp(bp, got);
   endtask

   logic [31:0] got;
   logic [6:0]  ra;
   logic [2:0]  rf;

   initial begin
      for (int i = 0; i < 32; i++) begin
         phys_mem[i] = $urandom;
         ref_mem[i]  = phys_mem[i];
      end
      phys_mem[2] = 32'h12345678;
      ref_mem[2]  = 32'h12345678;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      issue(1, 3'b010, 7'h0C, 32'hDEADBEEF, 0, got);
      chk("sw word3", phys_mem[3], 32'hDEADBEEF);
      issue(0, 3'b010, 7'h0C, 32'h0, 0, got);
      chk("lw 0x0C", got, 32'hDEADBEEF);
      chk("model lw 0x0C", e_rdata, 32'hDEADBEEF);

      issue(1, 3'b000, 7'h0D, 32'h1234565A, 1, got);
      chk("sb word3", phys_mem[3], 32'hDEAD5AEF);
      chk("model sb word3", ref_mem[3], 32'hDEAD5AEF);
      issue(0, 3'b100, 7'h0D, 32'h0, 0, got);
      chk("lbu 0x0D", got, 32'h0000005A);
      issue(0, 3'b000, 7'h0F, 32'h0, 2, got);
      chk("lb 0x0F", got, 32'hFFFFFFDE);
      chk("model lb 0x0F", e_rdata, 32'hFFFFFFDE);

      issue(1, 3'b001, 7'h0E, 32'hFFFF8001, 0, got);
      chk("sh word3", phys_mem[3], 32'h80015AEF);
      issue(0, 3'b001, 7'h0E, 32'h0, 0, got);
      chk("lh 0x0E", got, 32'hFFFF8001);
      issue(0, 3'b101, 7'h0E, 32'h0, 0, got);
      chk("lhu 0x0E", got, 32'h00008001);

      issue(0, 3'b010, 7'h05, 32'h0, 0, got);
      chk("lw 0x05 rdata", got, 0);
      chk("model lw 0x05 err", e_err, 1);
      issue(1, 3'b001, 7'h03, 32'hFFFF, 1, got);
      chk("model sh 0x03 err", e_err, 1);
      issue(0, 3'b011, 7'h00, 32'h0, 0, got);
      chk("funct3 011 rdata", got, 0);
      issue(1, 3'b100, 7'h10, 32'h77, 0, got);
      chk("store f3 100 err", e_err, 1);
      chk("word3 after errors", phys_mem[3], 32'h80015AEF);

      // Backpressure with a second request waiting.
      @(negedge clk);
      drive(0, 3'b010, 7'h0C, 32'h0);
      wait_accept();
      drive(0, 3'b100, 7'h0D, 32'h0);
      wait_resp(4, got);
      chk("bp lw 0x0C", got, 32'h80015AEF);
      wait_accept();
      req_valid = 1'b0;
      chk("accept after handshake", acc_at, hs_at + 1);
      wait_resp(0, got);
      chk("queued lbu 0x0D", got, 32'h0000005A);

      // Reset while the word store is in WRITE.
      @(negedge clk);
      drive(1, 3'b010, 7'h08, 32'hCAFEF00D);
      wait_accept();
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("mem_write after rst_n fall", mem_write, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset req_ready", req_ready, 1);
      chk("word2 untouched", phys_mem[2], 32'h12345678);

      for (int t = 0; t < 200; t++) begin
         rf = 3'($urandom_range(0, 7));
         ra = 7'($urandom);
         if ($urandom_range(0, 2) != 0) ra[1:0] = 2'b00;
         issue(1'($urandom), rf, ra, $urandom, $urandom_range(0, 3), got);
      end

      for (int i = 0; i < 32; i++) chk($sformatf("final word %0d", i), phys_mem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/risc_v_lsu.md
Name: risc_v_lsu

Overview:
- Load/store initiator for the RISC-V datapath. Accepts byte-addressed load/store requests from the core and drives the word-wide, single-port data memory: combinational read, write on the rising clock edge when the write strobe is high.
- Handles byte, halfword and word accesses, with sign/zero extension on loads.
- Performs read-modify-write for sub-word stores.
- Reports misaligned accesses as errors without touching memory.

Parameters:
- DATA_WIDTH, 32, data word width; fixed at 32 for funct3 semantics.
- ADDR_WIDTH, 5, word-address width of the memory port.
- BYTE_ADDR_WIDTH, ADDR_WIDTH+2, width of the core-side byte address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  LSU can accept a request (IDLE only).
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- req_addr  in  BYTE_ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, taken from the low bytes.
- resp_valid  out  1  response available.
- resp_ready  in  1  core consumes the response.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address, equal to req_addr[BYTE_ADDR_WIDTH-1:2].
- mem_wdata  out  DATA_WIDTH  write data to memory.
- mem_rdata  in  DATA_WIDTH  combinational read data from memory.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_write=0, mem_addr=0, mem_wdata=0.
  - All latched request fields are cleared.
  - Reset mid-operation abandons the access. No write strobe may be emitted after rst_n falls.
- Request acceptance:
  - A request is accepted on an edge where req_valid && req_ready.
  - The LSU latches write, funct3, addr and wdata at acceptance.
  - After acceptance it ignores the req_* inputs until it returns to IDLE.
- Error checks, evaluated at acceptance:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Illegal: funct3 011, 110 or 111, or a store with funct3 100 or 101.
  - Either case goes IDLE→RESP with resp_err=1. There is no memory access, and mem_write stays 0.
- FSM states: IDLE, READ, WRITE, RESP.
  - Load: IDLE→READ→RESP. In READ, mem_addr is driven and mem_rdata is registered at the end of the cycle.
  - Word store: IDLE→WRITE→RESP.
  - Sub-word store: IDLE→READ→WRITE→RESP (read-modify-write).
  - RESP: resp_valid=1, held stable until resp_ready. On the edge with resp_valid && resp_ready, go to IDLE.
  - Back-to-back: a new request is accepted no earlier than the cycle after the response handshake.
- Latency, counting edges after acceptance:
  - Load: resp_valid asserted after 2 edges.
  - Word store: 2 edges.
  - Sub-word store: 3 edges.
  - Error: 1 edge.
- Memory port rules:
  - mem_addr holds the latched word address in READ and WRITE, and 0 otherwise.
  - mem_write=1 only in WRITE, for exactly one cycle per store.
- Store data and merge:
  - sw: mem_wdata = wdata.
  - sb: the byte lane addr[1:0] of the read word is replaced by wdata[7:0].
  - sh: lane addr[1] (bits 15:0 or 31:16) is replaced by wdata[15:0].
  - The other lanes keep the value captured in READ.
- Load extraction:
  - Select the lane by addr[1:0] from the registered word.
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw passes the word through.
- Outputs are driven from registers or the state decode only. No combinational path from req_* to mem_*.

Test Plan:
- Reset: rst_n=0 mid-WRITE of sw to 0x08 → mem_write drops immediately; after release, state is IDLE, req_ready=1, word 2 is unchanged.
- sw then lw: sw 0xDEADBEEF to addr 0x0C → one mem_write pulse with mem_addr=3; lw addr 0x0C → resp_rdata=0xDEADBEEF after 2 edges.
- Sub-word store: word 3 = 0xDEADBEEF; sb 0x5A to addr 0x0D → READ, then WRITE with mem_wdata=0xDEAD5AEF; following lbu 0x0D → 0x0000005A, lb 0x0F → 0xFFFFFFDE.
- Halfword: sh 0x8001 to 0x0E → word 0x8001_5AEF; lh 0x0E → 0xFFFF8001; lhu 0x0E → 0x00008001.
- Errors: lw at 0x05, sh at 0x03, and funct3=011 → resp_err=1 after 1 edge, resp_rdata=0, mem_write never asserted.
- Backpressure: resp_ready held 0 for 4 cycles after lw 0x0C → resp_valid and resp_rdata stay stable, req_ready=0 and a new req_valid is ignored; accepted the cycle after resp_ready=1.
